// File: rtl/ov_pkg.sv
// Shared types and default constants for the OV camera capture controller.
package ov_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_LO,
    SYNC_HI,
    WRST,
    WEN_ON,
    ACTIVE,
    READY,
    READING
  } state_e;

  localparam int unsigned EXP_LINES_DEF   = 480;
  localparam int unsigned TIMEOUT_CYC_DEF = 4_800_000;

endpackage

// File: rtl/ov_sync2.sv
// Two-flop synchroniser for an asynchronous pin, plus single-cycle rise/fall
// pulses derived from the synchronised level.
module ov_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  // [0],[1] are the synchroniser; [2] holds the previous synchronised level
  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign rise_c = sh_q[1] & ~sh_q[2];
  assign fall_c = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/ov_capture_ctrl.sv
// Frame capture sequencer for an OV camera feeding a write-side FIFO:
// frame alignment, decimation, line-count validation and a stall watchdog.
module ov_capture_ctrl
  import ov_pkg::*;
#(
  parameter int unsigned EXP_LINES   = EXP_LINES_DEF,
  parameter int unsigned LINE_W      = 10,
  parameter int unsigned SKIP_W      = 4,
  parameter int unsigned TO_W        = 24,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_24MHz,
  input  logic              rst,
  input  logic              initialized,
  input  logic              mode_cont,
  input  logic              trig,
  input  logic [SKIP_W-1:0] skip,
  input  logic              vsync,
  input  logic              href,
  input  logic              frame_busy,
  output logic              wen,
  output logic              wrst,
  output logic              new_frame,
  output logic [LINE_W-1:0] frame_lines,
  output logic [15:0]       frame_cnt,
  output logic              err_lines,
  output logic              err_timeout
);

  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_W-1:0] LINE_EXP = LINE_W'(EXP_LINES);
  localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TIMEOUT_CYC - 1);

  logic vs_rise_c, vs_fall_c, hr_rise_c, hr_fall_c, fb_rise_c, fb_fall_c;

  ov_sync2 u_sync_vsync (.clk(clk_24MHz), .rst(rst), .d(vsync),
                         .rise_c(vs_rise_c), .fall_c(vs_fall_c));
  ov_sync2 u_sync_href  (.clk(clk_24MHz), .rst(rst), .d(href),
                         .rise_c(hr_rise_c), .fall_c(hr_fall_c));
  ov_sync2 u_sync_busy  (.clk(clk_24MHz), .rst(rst), .d(frame_busy),
                         .rise_c(fb_rise_c), .fall_c(fb_fall_c));

  state_e              state_q, state_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
  logic                armed_q, armed_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic                wen_q, wen_d;
  logic                wrst_q, wrst_d;
  logic                new_frame_q, new_frame_d;
  logic [LINE_W-1:0]   frame_lines_q, frame_lines_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                err_lines_q, err_lines_d;
  logic                err_timeout_q, err_timeout_d;
  logic                wd_run_c, timeout_c;

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    line_cnt_d    = line_cnt_q;
    armed_d       = armed_q;
    wen_d         = wen_q;
    wrst_d        = wrst_q;
    new_frame_d   = new_frame_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = frame_cnt_q;
    err_lines_d   = 1'b0;
    err_timeout_d = 1'b0;

    wd_run_c  = (state_q == SYNC_LO) || (state_q == SYNC_HI) || (state_q == WRST) ||
                (state_q == WEN_ON)  || (state_q == ACTIVE);
    timeout_c = wd_run_c && (wd_q == WD_LAST);

    // Loss of sensor config wins over everything; a timeout wins over vsync edges
    if (!initialized) begin
      state_d     = IDLE;
      wen_d       = 1'b0;
      wrst_d      = 1'b1;
      new_frame_d = 1'b0;
    end else if (timeout_c) begin
      err_timeout_d = 1'b1;
      wen_d         = 1'b0;
      wrst_d        = 1'b1;
      state_d       = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode_cont || trig) begin
            skip_cnt_d = '0;
            state_d    = SYNC_LO;
          end
        end
        SYNC_LO: begin
          if (vs_fall_c) state_d = SYNC_HI;
        end
        SYNC_HI: begin
          if (vs_rise_c) begin
            if (skip_cnt_q < skip) begin
              skip_cnt_d = SKIP_W'(skip_cnt_q + 1'b1);
              state_d    = SYNC_LO;
            end else begin
              wrst_d  = 1'b0;
              state_d = WRST;
            end
          end
        end
        WRST: begin
          wrst_d  = 1'b1;
          state_d = WEN_ON;
        end
        WEN_ON: begin
          wen_d      = 1'b1;
          line_cnt_d = '0;
          armed_d    = 1'b0;
          state_d    = ACTIVE;
        end
        ACTIVE: begin
          if (hr_rise_c && (line_cnt_q != LINE_MAX)) line_cnt_d = LINE_W'(line_cnt_q + 1'b1);
          if (vs_fall_c) armed_d = 1'b1;
          if (armed_q && vs_rise_c) begin
            wen_d         = 1'b0;
            frame_lines_d = line_cnt_q;
            if (line_cnt_q == LINE_EXP) begin
              new_frame_d = 1'b1;
              frame_cnt_d = 16'(frame_cnt_q + 16'd1);
              state_d     = READY;
            end else begin
              // retry the very next frame rather than decimating again
              err_lines_d = 1'b1;
              skip_cnt_d  = skip;
              state_d     = SYNC_LO;
            end
          end
        end
        READY: begin
          if (fb_rise_c) state_d = READING;
        end
        READING: begin
          if (fb_fall_c) begin
            new_frame_d = 1'b0;
            if (mode_cont) begin
              skip_cnt_d = '0;
              state_d    = SYNC_LO;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (!wd_run_c || vs_rise_c || vs_fall_c || (state_d != state_q)) wd_d = '0;
    else                                                             wd_d = TO_W'(wd_q + 1'b1);
  end

  always_ff @(posedge clk_24MHz or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      skip_cnt_q    <= '0;
      line_cnt_q    <= '0;
      armed_q       <= 1'b0;
      wd_q          <= '0;
      wen_q         <= 1'b0;
      wrst_q        <= 1'b1;
      new_frame_q   <= 1'b0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      err_lines_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      line_cnt_q    <= line_cnt_d;
      armed_q       <= armed_d;
      wd_q          <= wd_d;
      wen_q         <= wen_d;
      wrst_q        <= wrst_d;
      new_frame_q   <= new_frame_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      err_lines_q   <= err_lines_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign wen         = wen_q;
  assign wrst        = wrst_q;
  assign new_frame   = new_frame_q;
  assign frame_lines = frame_lines_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_lines   = err_lines_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ov_capture_ctrl.sv
// Frame-level bench for ov_capture_ctrl: drives whole camera frames and predicts
// which frame is captured, its outcome and the counters from frame indices.
module tb_ov_capture_ctrl;

  localparam int EXP      = 200;
  localparam int LW       = 8;
  localparam int SW       = 4;
  localparam int TO       = 1000;
  localparam int SYNC_LAT = 3;
  localparam int LMAX     = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          initialized, mode_cont, trig;
  logic [SW-1:0] skip;
  logic          vsync, href, frame_busy;
  logic          wen, wrst, new_frame;
  logic [LW-1:0] frame_lines;
  logic [15:0]   frame_cnt;
  logic          err_lines, err_timeout;

  ov_capture_ctrl #(
    .EXP_LINES(EXP), .LINE_W(LW), .SKIP_W(SW), .TO_W(24), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_24MHz(clk), .rst(rst), .initialized(initialized), .mode_cont(mode_cont),
    .trig(trig), .skip(skip), .vsync(vsync), .href(href), .frame_busy(frame_busy),
    .wen(wen), .wrst(wrst), .new_frame(new_frame), .frame_lines(frame_lines),
    .frame_cnt(frame_cnt), .err_lines(err_lines), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int wrst_low_n, errl_n, tmo_n, wen_n;

  // frame-level reference model state
  int f;          // index of the frame being driven
  int cap;        // index of the next frame the controller will capture, -1 = none
  int skip_v;
  int exp_cnt;
  int pend;       // previous frame was captured, outcome visible at next vsync rise
  int pend_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (wrst === 1'b0)       wrst_low_n++;
    if (err_lines === 1'b1)  errl_n++;
    if (err_timeout === 1'b1) tmo_n++;
    if (wen === 1'b1)        wen_n++;
  endtask

  function automatic int lmin(input int a);
    return (a > LMAX) ? LMAX : a;
  endfunction

  // act: 0 none, 1 drop initialized mid-frame, 2 trig pulse, 3 reset mid-frame
  task automatic frame(input int n, input int act);
    int t0, exp_err, ok, aborted;
    logic capt;
    wrst_low_n = 0;
    errl_n     = 0;
    exp_err    = 0;
    aborted    = 0;
    t0         = cycle;
    vsync      = 1'b1;
    repeat (8) cyc();
    if (pend != 0) begin
      ok = (pend_n == EXP) ? 1 : 0;
      if (ok != 0) exp_cnt++;
      chk("frame_lines", 32'(frame_lines), 32'(lmin(pend_n)));
      chk("new_frame_set", 32'(new_frame), 32'(ok));
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      chk("wen_end", 32'(wen), 32'd0);
      if (ok != 0) begin
        frame_busy = 1'b1;
        repeat (3) cyc();
        frame_busy = 1'b0;
        repeat (5) cyc();
        chk("new_frame_clr", 32'(new_frame), 32'd0);
        cap = (mode_cont == 1'b1) ? f + 1 + skip_v : -1;
      end else begin
        exp_err = 1;
        cap     = f + 1;
      end
      pend = 0;
    end
    capt = (f == cap);
    while (cycle - t0 < 30) cyc();
    vsync = 1'b0;
    repeat (10) cyc();
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      cyc();
      href = 1'b0;
      cyc();
      if (i == n / 2) begin
        chk("wen_mid", 32'(wen), 32'(capt));
        if (act == 1) begin
          initialized = 1'b0;
          cyc();
          chk("init_drop_wen", 32'(wen), 32'd0);
          chk("init_drop_wrst", 32'(wrst), 32'd1);
          chk("init_drop_nf", 32'(new_frame), 32'd0);
          skip_v      = 2;
          skip        = SW'(skip_v);
          initialized = 1'b1;
          cap         = f + 2 + skip_v;
          aborted     = 1;
        end else if (act == 2) begin
          trig = 1'b1;
          cyc();
          trig = 1'b0;
          if (cap < 0) cap = f + 2 + skip_v;
        end else if (act == 3) begin
          rst = 1'b1;
          #1;
          chk("rst_wen", 32'(wen), 32'd0);
          chk("rst_wrst", 32'(wrst), 32'd1);
          chk("rst_nf", 32'(new_frame), 32'd0);
          chk("rst_fcnt", 32'(frame_cnt), 32'd0);
          chk("rst_flines", 32'(frame_lines), 32'd0);
          cyc();
          rst     = 1'b0;
          exp_cnt = 0;
          cap     = f + 2 + skip_v;
          aborted = 1;
        end
      end
    end
    repeat (10) cyc();
    chk("wrst_pulse", 32'(wrst_low_n), 32'(capt));
    chk("err_lines_pulse", 32'(errl_n), 32'(exp_err));
    pend   = (capt && aborted == 0) ? 1 : 0;
    pend_n = n;
    f++;
  endtask

  initial begin
    int lines_a [8];
    int k, n;
    rst = 1'b1; initialized = 1'b0; mode_cont = 1'b0; trig = 1'b0; skip = '0;
    vsync = 1'b0; href = 1'b0; frame_busy = 1'b0;
    wrst_low_n = 0; errl_n = 0; tmo_n = 0; wen_n = 0;
    f = 0; cap = -1; skip_v = 0; exp_cnt = 0; pend = 0; pend_n = 0;
    repeat (3) cyc();
    chk("reset_wen", 32'(wen), 32'd0);
    chk("reset_wrst", 32'(wrst), 32'd1);
    chk("reset_nf", 32'(new_frame), 32'd0);
    chk("reset_flines", 32'(frame_lines), 32'd0);
    chk("reset_fcnt", 32'(frame_cnt), 32'd0);
    chk("reset_errl", 32'(err_lines), 32'd0);
    chk("reset_errt", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    repeat (5) cyc();
    chk("uninit_wrst", 32'(wrst), 32'd1);

    // continuous, no decimation: good frame, short frame, saturating frame, good frame
    for (int i = 0; i < 8; i++) lines_a[i] = $urandom_range(EXP + 3, EXP - 3);
    lines_a[1] = EXP;
    lines_a[3] = EXP - 1;
    lines_a[5] = LMAX + 5;
    lines_a[7] = EXP;
    mode_cont = 1'b1; initialized = 1'b1; skip = '0; skip_v = 0;
    repeat (5) cyc();
    cap = f + 1 + skip_v;
    for (int i = 0; i < 8; i++) frame(lines_a[i], (i == 2) ? 2 : 0);

    // drop initialized in the middle of a captured frame, resume with skip=2
    k = 0;
    while (f != cap && k < 10) begin
      frame(EXP, 0);
      k++;
    end
    frame(EXP, 1);
    for (int i = 0; i < 10; i++) begin
      n = ($urandom_range(3, 0) == 0) ? EXP - 1 : EXP;
      frame(n, 0);
    end

    // single-shot: finish current capture, stay idle, then one triggered capture
    mode_cont = 1'b0;
    k = 0;
    while (!(cap == -1 && pend == 0) && k < 20) begin
      frame(EXP, 0);
      k++;
    end
    frame(EXP, 0);
    frame(EXP, 0);
    frame(EXP, 2);
    k = 0;
    while (!(cap == -1 && pend == 0) && k < 20) begin
      frame(EXP, 0);
      k++;
    end
    frame(EXP, 0);

    // watchdog: trig, then hold vsync low after one falling edge
    vsync = 1'b1;
    trig  = 1'b1;
    cyc();
    trig = 1'b0;
    repeat (10) cyc();
    tmo_n = 0;
    vsync = 1'b0;
    k = 0;
    while (err_timeout !== 1'b1 && k < TO + 100) begin
      cyc();
      k++;
    end
    chk("timeout_latency", 32'(k), 32'(TO + SYNC_LAT));
    chk("timeout_wen", 32'(wen), 32'd0);
    chk("timeout_wrst", 32'(wrst), 32'd1);
    cyc();
    chk("timeout_pulse_end", 32'(err_timeout), 32'd0);
    wen_n = 0;
    repeat (50) cyc();
    chk("timeout_idle_wen", 32'(wen_n), 32'd0);
    chk("timeout_pulses", 32'(tmo_n), 32'd1);

    // continuous again, reset in the middle of a captured frame, then recover
    mode_cont = 1'b1;
    repeat (3) cyc();
    cap = f + 1 + skip_v;
    k = 0;
    while (f != cap && k < 10) begin
      frame(EXP, 0);
      k++;
    end
    frame(EXP, 3);
    k = 0;
    while ((exp_cnt == 0 || pend != 0) && k < 10) begin
      frame(EXP, 0);
      k++;
    end
    chk("recover_cnt", 32'(frame_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
